mem_data_responder: RTL

MEM_DATA_RESPONDER -- requirements
Module: mem_data_responder

---
 rtl/mem_data_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_data_responder.sv
// rtl/mem_data_responder.sv - word-addressed 18-bit memory responder with
// odd byte-parity checking, fault injection and programmable read latency.
module mem_data_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int READ_LAT   = 2
) (
  input  logic                  sysclk,
  input  logic                  sys_rst,
  input  logic                  MREQ_n,
  input  logic                  MWRITE_n,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [17:0]           DD_17_0_IN,
  input  logic                  INJ_LO,
  input  logic                  INJ_HI,
  input  logic                  CLRERR_n,
  output logic [17:0]           DD_17_0_OUT,
  output logic                  DD_OE,
  output logic                  MACK_n,
  output logic                  WPERR_LO,
  output logic                  WPERR_HI
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [2:0] LAST_WAIT = (READ_LAT > 0) ? 3'(READ_LAT - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WR, RWAIT, ACK} state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [17:0]           wdata_q;
  logic [2:0]            wait_cnt;
  logic [17:0]           rdata_q;
  logic [17:0]           mem [DEPTH];

  logic                  req;
  logic                  start;
  logic                  load_rdata;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  mem_we;
  logic [17:0]           mem_wdata;
  logic                  perr_lo;
  logic                  perr_hi;

  assign req   = ~MREQ_n;
  assign start = (state == IDLE) && req;

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (!MWRITE_n) begin
            next_state = WR;
          end else if (READ_LAT > 0) begin
            next_state = RWAIT;
          end else begin
            next_state = ACK;
          end
        end
      end
      WR:      next_state = ACK;
      RWAIT:   if (wait_cnt == LAST_WAIT) next_state = ACK;
      ACK:     if (!req) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A zero-latency read goes straight from IDLE to ACK, so it must fetch with
  // the live ADDR rather than the not-yet-loaded address register.
  assign load_rdata = (next_state == ACK) && ((state == IDLE) || (state == RWAIT));
  assign rd_addr    = (state == IDLE) ? ADDR : addr_q;

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      wait_cnt <= 3'd0;
      rdata_q  <= '0;
    end else begin
      if (start) begin
        addr_q  <= ADDR;
        write_q <= ~MWRITE_n;
        wdata_q <= DD_17_0_IN;
      end
      if (state == RWAIT) begin
        wait_cnt <= wait_cnt + 3'd1;
      end else begin
        wait_cnt <= 3'd0;
      end
      if (load_rdata) begin
        rdata_q <= mem[rd_addr];
      end
    end
  end

  // Reset forces the state out of WR asynchronously, which is what suppresses
  // an interrupted write; the array itself is never reset.
  assign mem_we    = (state == WR);
  assign mem_wdata = {wdata_q[17] ^ INJ_HI, wdata_q[16:9], wdata_q[8] ^ INJ_LO, wdata_q[7:0]};

  always_ff @(posedge sysclk) begin
    if (mem_we) begin
      mem[addr_q] <= mem_wdata;
    end
  end

  // Odd parity: a group with an even number of ones is a bus error.
  assign perr_lo = mem_we && !(^wdata_q[8:0]);
  assign perr_hi = mem_we && !(^wdata_q[17:9]);

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      WPERR_LO <= 1'b0;
      WPERR_HI <= 1'b0;
    end else begin
      WPERR_LO <= perr_lo | (WPERR_LO & CLRERR_n);
      WPERR_HI <= perr_hi | (WPERR_HI & CLRERR_n);
    end
  end

  always_comb begin
    MACK_n      = 1'b1;
    DD_OE       = 1'b0;
    DD_17_0_OUT = '0;
    if (state == ACK) begin
      MACK_n = 1'b0;
      if (!write_q) begin
        DD_OE       = 1'b1;
        DD_17_0_OUT = rdata_q;
      end
    end
  end

endmodule
